alu_cmd_sequencer: RTL

- Issue-side controller for the team's combinational 16-bit ALU (inputs Din1/Din2/MS, output ALU_out).
- Accepts register-to-register commands on a valid/ready interface and reads operands from a small local register file.
- Drives the ALU from registered outputs, captures the result, writes it back, and returns it on a valid/ready response channel.
- Traps divide-by-zero, modulo-by-zero and the unused opcode before they reach the ALU.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Issue-side controller for the 16-bit combinational ALU: accepts register-to-register
// commands, drives the ALU from registered operands, writes back and returns the result.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] Din1,
    output logic [WIDTH-1:0] Din2,
    output logic [2:0]       MS,
    input  logic [WIDTH-1:0] ALU_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [AW-1:0]    rsp_rd
);

    localparam int unsigned NREGS = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rf [NREGS];
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic             trap;
    logic             accept;

    assign rs1_val = rf[rs1_q];
    assign rs2_val = rf[rs2_q];

    // Zero divisors and the unused opcode never reach the ALU.
    assign trap = (op_q == 3'b000) ||
                  (((op_q == 3'b100) || (op_q == 3'b110)) && (rs2_val == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                accept    = cmd_valid & ~rst;
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = trap ? RESP : CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf       <= '{default: '0};
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            Din1     <= '0;
            Din2     <= '0;
            MS       <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_rd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A same-cycle load lands before ISSUE reads the file.
                    if (ld_en) begin
                        rf[ld_addr] <= ld_data;
                    end
                    if (accept) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                    end
                end
                ISSUE: begin
                    if (trap) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        rsp_rd   <= rd_q;
                    end else begin
                        Din1 <= rs1_val;
                        Din2 <= rs2_val;
                        MS   <= op_q;
                    end
                end
                CAPT: begin
                    rf[rd_q] <= ALU_out;
                    rsp_data <= ALU_out;
                    rsp_err  <= 1'b0;
                    rsp_rd   <= rd_q;
                end
                RESP: begin
                    if (rsp_ready) begin
                        MS <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
